// File: rtl/serial_cnt_pkg.sv
// Shared types and helpers for the serial bit counter controller.
package serial_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        REPORT   = 2'd2,
        WAIT_LOW = 2'd3
    } state_e;

    localparam logic MODE_ONES  = 1'b0;
    localparam logic MODE_ZEROS = 1'b1;

    // True when the sampled bit has the polarity selected by mode_v.
    function automatic logic bit_match(input logic bit_v, input logic mode_v);
        logic m;
        case (mode_v)
            MODE_ONES:  m = bit_v;
            MODE_ZEROS: m = ~bit_v;
            default:    m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/serial_bit_counter_ctrl_if.sv
// Result handshake bundle of serial_bit_counter_ctrl; max_run exists only with MAX_RUN_EN.
interface serial_bit_counter_ctrl_if #(
    parameter int CW = 8
);
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] count;
    logic [CW-1:0] total;
    logic          overflow;
    logic          truncated;
`ifdef MAX_RUN_EN
    logic [CW-1:0] max_run;

    modport master (output out_valid, count, total, overflow, truncated, max_run, input out_ready);
    modport slave  (input out_valid, count, total, overflow, truncated, max_run, output out_ready);
`else
    modport master (output out_valid, count, total, overflow, truncated, input out_ready);
    modport slave  (input out_valid, count, total, overflow, truncated, output out_ready);
`endif
endinterface

// File: rtl/serial_bit_counter_ctrl_sat_counter.sv
// Saturating up-counter with clear-and-load; sat flags that the next value is all ones.
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          sat
);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] nxt_s;

    // Clear loads the first sample so a frame start counts its own bit.
    always_comb begin
        nxt_s = cnt_r;
        if (clr) begin
            nxt_s = CW'(inc);
        end else if (inc && (cnt_r != CNT_MAX)) begin
            nxt_s = cnt_r + CW'(1'b1);
        end else begin
            nxt_s = cnt_r;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= nxt_s;
        end
    end

    assign cnt = cnt_r;
    assign sat = (nxt_s == CNT_MAX);

endmodule

// File: rtl/serial_bit_counter_ctrl.sv
// Serial frame bit counter with length limit, saturation and drop reporting.
// Define MAX_RUN_EN to add the longest-matching-run output on the result interface.
module serial_bit_counter_ctrl #(
    parameter int CW       = 8,
    parameter int MAX_BITS = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic serin,
    input  logic collect,
    input  logic mode,
    serial_bit_counter_ctrl_if.master res,
    output logic dropped,
    output logic busy
);
    import serial_cnt_pkg::*;

    // Value of total just before the closing sample of a full-length frame.
    localparam logic [CW-1:0] LAST_PRE = CW'(MAX_BITS - 1);

    state_e        state_r;
    state_e        state_nxt_s;
    logic          mode_r;
    logic          collect_q_r;
    logic          out_valid_r;
    logic          overflow_r;
    logic          truncated_r;
    logic          dropped_r;
    logic          busy_r;
    logic          start_s;
    logic          sample_s;
    logic          match_s;
    logic          close_trunc_s;
    logic          drop_s;
    logic          ovf_hit_s;
    logic [CW-1:0] count_s;
    logic [CW-1:0] total_s;
    logic          count_sat_s;
    logic          total_sat_s;

    sat_counter #(.CW(CW)) u_count (
        .clk (clk),
        .rst (rst),
        .clr (start_s),
        .inc (sample_s & match_s),
        .cnt (count_s),
        .sat (count_sat_s)
    );

    sat_counter #(.CW(CW)) u_total (
        .clk (clk),
        .rst (rst),
        .clr (start_s),
        .inc (sample_s),
        .cnt (total_s),
        .sat (total_sat_s)
    );

`ifdef MAX_RUN_EN
    logic [CW-1:0] cur_run_s;
    logic [CW-1:0] max_run_s;
    logic          cur_sat_s;
    logic          max_sat_s;

    sat_counter #(.CW(CW)) u_cur_run (
        .clk (clk),
        .rst (rst),
        .clr (start_s | (sample_s & ~match_s)),
        .inc (sample_s & match_s),
        .cnt (cur_run_s),
        .sat (cur_sat_s)
    );

    // The best run only grows while the current run is the best run.
    sat_counter #(.CW(CW)) u_max_run (
        .clk (clk),
        .rst (rst),
        .clr (start_s),
        .inc (sample_s & match_s & (start_s | (cur_run_s == max_run_s))),
        .cnt (max_run_s),
        .sat (max_sat_s)
    );

    // A run never exceeds count, so folding run saturation in cannot change overflow.
    assign ovf_hit_s     = count_sat_s | total_sat_s | cur_sat_s | max_sat_s;
    assign res.max_run   = max_run_s;
`else
    assign ovf_hit_s     = count_sat_s | total_sat_s;
`endif

    // Next-state and sample/start strobes.
    always_comb begin
        state_nxt_s   = state_r;
        start_s       = 1'b0;
        sample_s      = 1'b0;
        close_trunc_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (collect) begin
                    start_s  = 1'b1;
                    sample_s = 1'b1;
                    if (LAST_PRE == {CW{1'b0}}) begin
                        close_trunc_s = 1'b1;
                        state_nxt_s   = REPORT;
                    end else begin
                        state_nxt_s   = COLLECT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            COLLECT: begin
                if (collect) begin
                    sample_s = 1'b1;
                    if (total_s == LAST_PRE) begin
                        close_trunc_s = 1'b1;
                        state_nxt_s   = REPORT;
                    end else begin
                        state_nxt_s   = COLLECT;
                    end
                end else begin
                    state_nxt_s = REPORT;
                end
            end
            REPORT: begin
                if (res.out_ready) begin
                    if (truncated_r && collect) begin
                        state_nxt_s = WAIT_LOW;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = REPORT;
                end
            end
            WAIT_LOW: begin
                if (collect) begin
                    state_nxt_s = WAIT_LOW;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Bit polarity match and lost-frame detection.
    always_comb begin
        match_s = 1'b0;
        drop_s  = 1'b0;
        if (state_r == IDLE) begin
            match_s = bit_match(serin, mode);
        end else begin
            match_s = bit_match(serin, mode_r);
        end
        if (((state_r == REPORT) || (state_r == WAIT_LOW)) && collect && !collect_q_r) begin
            drop_s = 1'b1;
        end else begin
            drop_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Frame flags and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_r      <= MODE_ONES;
            collect_q_r <= 1'b0;
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            truncated_r <= 1'b0;
            dropped_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            collect_q_r <= collect;
            out_valid_r <= (state_nxt_s == REPORT);
            busy_r      <= (state_nxt_s != IDLE);
            dropped_r   <= drop_s;
            if (start_s) begin
                mode_r      <= mode;
                overflow_r  <= ovf_hit_s;
                truncated_r <= close_trunc_s;
            end else if (sample_s) begin
                mode_r      <= mode_r;
                overflow_r  <= overflow_r | ovf_hit_s;
                truncated_r <= truncated_r | close_trunc_s;
            end else begin
                mode_r      <= mode_r;
                overflow_r  <= overflow_r;
                truncated_r <= truncated_r;
            end
        end
    end

    assign res.out_valid = out_valid_r;
    assign res.count     = count_s;
    assign res.total     = total_s;
    assign res.overflow  = overflow_r;
    assign res.truncated = truncated_r;
    assign dropped       = dropped_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_serial_bit_counter_ctrl.sv
// Scoreboard bench for serial_bit_counter_ctrl: two instances (CW=8/MAX_BITS=8 and CW=3/MAX_BITS=7).
module tb_serial_bit_counter_ctrl;

    typedef struct packed {
        logic [7:0] count;
        logic [7:0] total;
        logic       ovf;
        logic       trunc;
        logic [7:0] max_run;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    logic clk = 1'b0;
    logic rst;
    logic serin_a, collect_a, mode_a, dropped_a, busy_a;
    logic serin_b, collect_b, mode_b, dropped_b, busy_b;

    exp_t qa[$];
    exp_t qb[$];
    chk_t chkq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   drop_cnt_a = 0;
    int   base;

    serial_bit_counter_ctrl_if #(.CW(8)) ifa ();
    serial_bit_counter_ctrl_if #(.CW(3)) ifb ();

    serial_bit_counter_ctrl #(.CW(8), .MAX_BITS(8)) dut_a (
        .clk     (clk),
        .rst     (rst),
        .serin   (serin_a),
        .collect (collect_a),
        .mode    (mode_a),
        .res     (ifa),
        .dropped (dropped_a),
        .busy    (busy_a)
    );

    serial_bit_counter_ctrl #(.CW(3), .MAX_BITS(7)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .serin   (serin_b),
        .collect (collect_b),
        .mode    (mode_b),
        .res     (ifb),
        .dropped (dropped_b),
        .busy    (busy_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        chk_t c;
        c.name = nm;
        c.act  = a;
        c.exp  = e;
        chkq.push_back(c);
    endtask

    task automatic push_a(input int c, input int t, input int ov, input int tr, input int mr);
        exp_t e;
        e.count   = 8'(c);
        e.total   = 8'(t);
        e.ovf     = ov[0];
        e.trunc   = tr[0];
        e.max_run = 8'(mr);
        qa.push_back(e);
    endtask

    task automatic push_b(input int c, input int t, input int ov, input int tr, input int mr);
        exp_t e;
        e.count   = 8'(c);
        e.total   = 8'(t);
        e.ovf     = ov[0];
        e.trunc   = tr[0];
        e.max_run = 8'(mr);
        qb.push_back(e);
    endtask

    // bits[0] is the first sampled bit.
    task automatic frame_a(input logic m, input logic [15:0] bits, input int n);
        mode_a    = m;
        collect_a = 1'b1;
        for (int i = 0; i < n; i++) begin
            serin_a = bits[i];
            tick();
        end
        collect_a = 1'b0;
        serin_a   = 1'b0;
        tick();
    endtask

    // Monitor: direct checks plus result pops whenever a handshake completes.
    always @(negedge clk) begin : mon
        chk_t c;
        exp_t e;
        while (chkq.size() > 0) begin
            c = chkq.pop_front();
            n_vec++;
            if (c.act !== c.exp) begin
                n_err++;
                $display("FAIL %s: got %0d required %0d", c.name, c.act, c.exp);
            end
        end
        if (rst === 1'b1 && ifa.out_valid === 1'b1 && ifa.out_ready === 1'b1) begin
            n_vec++;
            if (qa.size() == 0) begin
                n_err++;
                $display("FAIL a_unexpected_valid: got count=%0d total=%0d required no result",
                         ifa.count, ifa.total);
            end else begin
                e = qa.pop_front();
                if ({ifa.count, ifa.total, ifa.overflow, ifa.truncated} !== {e.count, e.total, e.ovf, e.trunc}) begin
                    n_err++;
                    $display("FAIL a_result: got count=%0d total=%0d ovf=%0b trunc=%0b required count=%0d total=%0d ovf=%0b trunc=%0b",
                             ifa.count, ifa.total, ifa.overflow, ifa.truncated, e.count, e.total, e.ovf, e.trunc);
                end
`ifdef MAX_RUN_EN
                n_vec++;
                if (ifa.max_run !== e.max_run) begin
                    n_err++;
                    $display("FAIL a_max_run: got %0d required %0d", ifa.max_run, e.max_run);
                end
`endif
            end
        end
        if (rst === 1'b1 && ifb.out_valid === 1'b1 && ifb.out_ready === 1'b1) begin
            n_vec++;
            if (qb.size() == 0) begin
                n_err++;
                $display("FAIL b_unexpected_valid: got count=%0d total=%0d required no result",
                         ifb.count, ifb.total);
            end else begin
                e = qb.pop_front();
                if ({5'b00000, ifb.count, 5'b00000, ifb.total, ifb.overflow, ifb.truncated} !== {e.count, e.total, e.ovf, e.trunc}) begin
                    n_err++;
                    $display("FAIL b_result: got count=%0d total=%0d ovf=%0b trunc=%0b required count=%0d total=%0d ovf=%0b trunc=%0b",
                             ifb.count, ifb.total, ifb.overflow, ifb.truncated, e.count, e.total, e.ovf, e.trunc);
                end
`ifdef MAX_RUN_EN
                n_vec++;
                if ({5'b00000, ifb.max_run} !== e.max_run) begin
                    n_err++;
                    $display("FAIL b_max_run: got %0d required %0d", ifb.max_run, e.max_run);
                end
`endif
            end
        end
    end

    // Count dropped pulses on instance A.
    always @(negedge clk) begin
        if (dropped_a === 1'b1) drop_cnt_a++;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        serin_a = 1'b0; collect_a = 1'b0; mode_a = 1'b0;
        serin_b = 1'b0; collect_b = 1'b0; mode_b = 1'b0;
        ifa.out_ready = 1'b1;
        ifb.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(ifa.out_valid), 32'd0);
        chk("rst_count", 32'(ifa.count), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_b_total", 32'(ifb.total), 32'd0);
        rst = 1'b1;
        tick();

        // Stream 1,1,0,1,1,1,0 counted as ones, then as zeros; then a one-cycle frame.
        push_a(5, 7, 0, 0, 3);
        frame_a(1'b0, 16'h003B, 7);
        tick();
        push_a(2, 7, 0, 0, 1);
        frame_a(1'b1, 16'h003B, 7);
        tick();
        push_a(0, 1, 0, 0, 0);
        frame_a(1'b0, 16'h0000, 1);
        tick();

        // Truncation at MAX_BITS=8 with collect held 12 cycles.
        push_a(8, 8, 0, 1, 8);
        mode_a = 1'b0; collect_a = 1'b1; serin_a = 1'b1;
        repeat (12) tick();
        chk("wait_low_busy", 32'(busy_a), 32'd1);
        chk("wait_low_no_valid", 32'(ifa.out_valid), 32'd0);
        collect_a = 1'b0; serin_a = 1'b0;
        tick();
        chk("wait_low_exit", 32'(busy_a), 32'd0);

        // CW=3 saturation with 10 ones.
        push_b(7, 7, 1, 1, 7);
        mode_b = 1'b0; collect_b = 1'b1; serin_b = 1'b1;
        repeat (10) tick();
        collect_b = 1'b0; serin_b = 1'b0;
        tick();
        chk("b_idle", 32'(busy_b), 32'd0);

        // Back-pressure with a lost frame start.
        ifa.out_ready = 1'b0;
        push_a(2, 3, 0, 0, 1);
        frame_a(1'b0, 16'h0005, 3);
        repeat (5) tick();
        chk("hold_valid", 32'(ifa.out_valid), 32'd1);
        chk("hold_count", 32'(ifa.count), 32'd2);
        chk("hold_total", 32'(ifa.total), 32'd3);
        base = drop_cnt_a;
        collect_a = 1'b1;
        tick();
        collect_a = 1'b0;
        tick();
        tick();
        chk("drop_once", 32'(drop_cnt_a - base), 32'd1);
        chk("hold_valid2", 32'(ifa.out_valid), 32'd1);
        ifa.out_ready = 1'b1;
        tick();
        chk("accept_idle", 32'(busy_a), 32'd0);

        // Back-to-back frames separated by one low cycle.
        push_a(2, 2, 0, 0, 2);
        push_a(1, 2, 0, 0, 1);
        base = drop_cnt_a;
        mode_a = 1'b0; collect_a = 1'b1; serin_a = 1'b1;
        tick();
        tick();
        collect_a = 1'b0;
        tick();
        collect_a = 1'b1; serin_a = 1'b1;
        tick();
        serin_a = 1'b0;
        tick();
        serin_a = 1'b1;
        tick();
        collect_a = 1'b0; serin_a = 1'b0;
        tick();
        tick();
        chk("b2b_drop", 32'(drop_cnt_a - base), 32'd1);

        // Asynchronous reset in the middle of a frame.
        collect_a = 1'b1; serin_a = 1'b1;
        tick();
        tick();
        #3;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(ifa.out_valid), 32'd0);
        chk("arst_count", 32'(ifa.count), 32'd0);
        chk("arst_total", 32'(ifa.total), 32'd0);
        chk("arst_busy", 32'(busy_a), 32'd0);
        chk("arst_flags", 32'({ifa.overflow, ifa.truncated, dropped_a}), 32'd0);
        collect_a = 1'b0; serin_a = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        tick();
        push_a(3, 3, 0, 0, 3);
        frame_a(1'b0, 16'h0007, 3);
        repeat (4) tick();

        chk("a_pending", 32'(qa.size()), 32'd0);
        chk("b_pending", 32'(qb.size()), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
